// File: rtl/bn_updown_counter.sv
// Modulo-MOD up/down counter with parallel load and a combinational cascade output.
// Define BN_COUNTER_SAT_EN to saturate at the terminal count instead of wrapping.
module bn_updown_counter #(
  parameter int unsigned N   = 4,
  parameter int unsigned MOD = 10
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         ei,
  input  logic         up,
  input  logic         ld,
  input  logic [N-1:0] d,
  output logic [N-1:0] q,
  output logic         eu,
  output logic         tc
);

  // One extra bit keeps MOD == 2**N representable, so the last value never aliases.
  localparam logic [N:0] LastVal = (N+1)'(MOD - 1);
  localparam logic [N:0] One     = (N+1)'(1);

  logic [N-1:0] count_q, count_d;
  logic [N:0]   count_ext, d_ext, step_ext, load_ext;
  logic         is_last, is_zero;

  assign count_ext = {1'b0, count_q};
  assign d_ext     = {1'b0, d};
  assign is_last   = (count_ext == LastVal);
  assign is_zero   = (count_q == '0);

  assign tc = up ? is_last : is_zero;
  assign eu = ei & ~ld & tc & ~reset;
  assign q  = count_q;

  always_comb begin
    step_ext = count_ext;
    if (up) begin
      step_ext = is_last ? '0 : (count_ext + One);
    end else begin
      step_ext = is_zero ? LastVal : (count_ext - One);
    end
  end

  // Out-of-range loads clamp to the top of the count range.
  assign load_ext = (d_ext > LastVal) ? LastVal : d_ext;

  always_comb begin
    count_d = count_q;
    if (ld) begin
      count_d = load_ext[N-1:0];
    end else if (ei) begin
`ifdef BN_COUNTER_SAT_EN
      if (!tc) begin
        count_d = step_ext[N-1:0];
      end
`else
      count_d = step_ext[N-1:0];
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: doc/bn_updown_counter.md
BN_UPDOWN_COUNTER -- requirements
Module: bn_updown_counter

Interface
REQ-001 Parameter N, default 4: counter width in bits; legal range 1..16.
REQ-002 Parameter MOD, default 10: counter modulus; legal range 2..2**N; the count range is 0..MOD-1.
REQ-003 clock  input  1  the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-005 ei  input  1  count enable, also the cascade-in from the less significant digit.
REQ-006 up  input  1  direction: 1 counts up, 0 counts down.
REQ-007 ld  input  1  parallel-load strobe.
REQ-008 d  input  N  parallel-load value.
REQ-009 q  output  N  current count, driven directly from the state register.
REQ-010 eu  output  1  cascade-out (carry when counting up, borrow when counting down), combinational.
REQ-011 tc  output  1  terminal-count flag, combinational.

Function
REQ-012 Priority on each rising edge SHALL be: reset, then ld, then ei, then hold.
REQ-013 ld=1: if d<MOD, the next q SHALL be d; if d>=MOD, the next q SHALL be clamped to MOD-1.
REQ-014 ei=1, ld=0, up=1: the next q SHALL be q+1 if q<MOD-1, else 0 (wrap).
REQ-015 ei=1, ld=0, up=0: the next q SHALL be q-1 if q>0, else MOD-1 (wrap).
REQ-016 ei=0, ld=0: q SHALL hold its value.
REQ-017 tc SHALL be 1 when (up=1 and q==MOD-1) or (up=0 and q==0); otherwise 0; tc is independent of ei.
REQ-018 eu SHALL equal ei & ~ld & tc & ~reset; eu is therefore asserted in exactly the cycle whose edge wraps the counter.
REQ-019 eu SHALL have zero-latency combinational dependency on ei, so that instances chained eu->ei form a multi-digit counter in which all digits update on the same edge.
REQ-020 A change of up while ei=1 SHALL take effect at the next edge with no extra cycle of latency and no skipped count.
REQ-021 The value of q SHALL never leave 0..MOD-1 in any case, including immediately after a load.
REQ-022 Arithmetic SHALL be performed internally on N+1 bits so that MOD=2**N wraps without overflow aliasing.

Reset
REQ-023 reset=1 at a rising edge SHALL force q=0, overriding ld and ei in the same cycle.
REQ-024 While reset=1: eu SHALL be 0; tc SHALL follow REQ-017 from the current q.
REQ-025 Reset asserted mid-count SHALL discard the count with no residual state; counting resumes from 0 on the first edge with reset=0 and ei=1.

Configuration
REQ-026 Macro BN_COUNTER_SAT_EN SHALL select the terminal-count behaviour.
REQ-027 With BN_COUNTER_SAT_EN undefined: the counter wraps as specified in REQ-014 and REQ-015.
REQ-028 With BN_COUNTER_SAT_EN defined: when ei=1, ld=0 and tc=1, q SHALL hold instead of wrapping; eu SHALL still assert per REQ-018, as an overflow/underflow indication; all other behaviour is unchanged.

Verification (N=4, MOD=10 unless stated)
REQ-029 Reset then down count: reset=1 for 1 edge, then ei=1, up=0 for 3 edges -> q = 0, 9, 8, 7; eu=1 only in the cycle with q=0.
REQ-030 Up wrap: load 8, then ei=1, up=1 for 3 edges -> q = 9, 0, 1; eu=1 and tc=1 while q=9.
REQ-031 Load clamp and priority: d=13, ld=1, ei=1 -> q=9; then reset=1, ld=1, d=5 -> q=0.
REQ-032 Cascade: two instances, units eu driving tens ei, count down from 10 -> values 09, then 08; from 00 -> 99.
REQ-033 Direction change at the boundary: q=0, up=0, ei=1 with up switched to 1 just before the edge -> q=1, eu=0.
REQ-034 With BN_COUNTER_SAT_EN defined and N=3, MOD=8: q=7, up=1, ei=1 for 2 edges -> q stays 7, eu=1 in both cycles.
